// File: rtl/mul_issue_arbiter.sv
// rtl/mul_issue_arbiter.sv - round-robin issue arbiter sharing one mul32 between two requesters
// Sequences mul32 start/return and buffers results in an in-order writeback FIFO.
module mul_issue_arbiter #(
    parameter int TAG_W      = 5,
    parameter int OBUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [TAG_W-1:0] req1_tag,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic             mul_in_en,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    output logic             mul_a_signed,
    output logic             mul_b_signed,
    input  logic             mul_idle,
    input  logic             mul_out_en,
    input  logic [31:0]      mul_sum_hi,
    input  logic [31:0]      mul_sum_lo,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_vregid,
    output logic [31:0]      wb_val,
    output logic             busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(OBUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(OBUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OBUF_DEPTH - 1);

    logic [1:0]       state_q, state_d;
    logic             rr_q, rr_d;
    logic             in_en_q;
    logic [31:0]      a_q, b_q;
    logic             as_q, bs_q;
    logic [2:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic [TAG_W-1:0] tag_mem [OBUF_DEPTH];
    logic [31:0]      val_mem [OBUF_DEPTH];

    logic       grant_ok, sel1, hs, push, pop;
    logic [2:0] sel_op;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // rr_q=1 favours req1; the lower-priority side wins only when the other is idle
    assign grant_ok   = (state_q == S_IDLE) && mul_idle && (count_q < DEPTH_C) && !flush;
    assign sel1       = req1_valid && (rr_q || !req0_valid);
    assign req0_ready = grant_ok && req0_valid && !sel1;
    assign req1_ready = grant_ok && sel1;
    assign hs         = req0_ready || req1_ready;
    assign sel_op     = sel1 ? req1_op : req0_op;

    assign push = (state_q == S_WAIT) && mul_out_en && !flush;
    assign pop  = (count_q != '0) && wb_ready && !flush;

    always_comb begin
        rr_d = rr_q;
        if (req0_ready) begin
            rr_d = 1'b1;
        end else if (req1_ready) begin
            rr_d = 1'b0;
        end
    end

    // a return coincident with flush in WAIT goes straight to IDLE, since DRAIN would never see it
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (hs) state_d = S_ISSUE;
            S_ISSUE: state_d = flush ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (mul_out_en)  state_d = S_IDLE;
                else if (flush)  state_d = S_DRAIN;
            end
            S_DRAIN: if (mul_out_en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_q     <= 1'b0;
            in_en_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            as_q     <= 1'b0;
            bs_q     <= 1'b0;
            op_q     <= '0;
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            in_en_q <= hs;
            if (hs) begin
                a_q   <= sel1 ? req1_a : req0_a;
                b_q   <= sel1 ? req1_b : req0_b;
                tag_q <= sel1 ? req1_tag : req0_tag;
                op_q  <= sel_op;
                as_q  <= !sel_op[1] || !sel_op[0];
                bs_q  <= !sel_op[1];
            end
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
                if (push && !pop)      count_q <= count_q + 1'b1;
                else if (pop && !push) count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= tag_q;
            val_mem[wr_ptr_q] <= (op_q == 3'b000) ? mul_sum_lo : mul_sum_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !pop) assert (count_q != DEPTH_C);
    end

    assign mul_in_en    = in_en_q;
    assign mul_a        = a_q;
    assign mul_b        = b_q;
    assign mul_a_signed = as_q;
    assign mul_b_signed = bs_q;

    assign wb_valid  = (count_q != '0);
    assign wb_vregid = tag_mem[rd_ptr_q];
    assign wb_val    = val_mem[rd_ptr_q];
    assign busy      = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_mul_issue_arbiter.sv
// tb/tb_mul_issue_arbiter.sv - scoreboard bench for mul_issue_arbiter with a behavioural mul32
module tb_mul_issue_arbiter;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic req0_valid = 1'b0, req1_valid = 1'b0;
    logic req0_ready, req1_ready;
    logic [2:0] req0_op = '0, req1_op = '0;
    logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic mul_in_en, mul_a_signed, mul_b_signed;
    logic [31:0] mul_a, mul_b;
    logic mul_idle = 1'b1, mul_out_en = 1'b0;
    logic [31:0] mul_sum_hi = '0, mul_sum_lo = '0;
    logic wb_valid, busy;
    logic wb_ready = 1'b0;
    logic [TAG_W-1:0] wb_vregid;
    logic [31:0] wb_val;

    int tests = 0;
    int fails = 0;
    logic [TAG_W+31:0] sb_q[$];
    logic [TAG_W-1:0] grant_log[$];
    logic last_as = 1'b0, last_bs = 1'b0;
    logic bp_done = 1'b0;

    always #5 clk = ~clk;

    mul_issue_arbiter #(.TAG_W(TAG_W), .OBUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_tag(req0_tag), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_tag(req1_tag), .req1_a(req1_a), .req1_b(req1_b),
        .mul_in_en(mul_in_en), .mul_a(mul_a), .mul_b(mul_b),
        .mul_a_signed(mul_a_signed), .mul_b_signed(mul_b_signed),
        .mul_idle(mul_idle), .mul_out_en(mul_out_en),
        .mul_sum_hi(mul_sum_hi), .mul_sum_lo(mul_sum_lo),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_vregid(wb_vregid),
        .wb_val(wb_val), .busy(busy)
    );

    // mul32 stand-in: three-cycle latency, busy while computing
    int mcnt = 0;
    logic signed [63:0] ea, eb, mprod;
    always @(negedge clk) begin
        if (!rst_n) begin
            mcnt = 0;
            mul_out_en = 1'b0;
            mul_idle = 1'b1;
        end else begin
            mul_out_en = 1'b0;
            if (mcnt != 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    mul_out_en = 1'b1;
                    mul_idle = 1'b1;
                    {mul_sum_hi, mul_sum_lo} = mprod;
                end
            end
            if (mul_in_en) begin
                ea = {{32{mul_a_signed & mul_a[31]}}, mul_a};
                eb = {{32{mul_b_signed & mul_b[31]}}, mul_b};
                mprod = ea * eb;
                last_as = mul_a_signed;
                last_bs = mul_b_signed;
                mcnt = 3;
                mul_idle = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_ready) grant_log.push_back(req0_tag);
            if (req1_ready) grant_log.push_back(req1_tag);
            if (wb_valid && wb_ready) begin
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL wb_unexpected: got tag %0d val %h, required no output", wb_vregid, wb_val);
                end else begin
                    logic [TAG_W+31:0] e;
                    e = sb_q.pop_front();
                    if ({wb_vregid, wb_val} !== e) begin
                        fails++;
                        $display("FAIL wb_result: got tag %0d val %h, required tag %0d val %h",
                                 wb_vregid, wb_val, e[TAG_W+31:32], e[31:0]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input logic [TAG_W-1:0] tag, input logic [31:0] val);
        sb_q.push_back({tag, val});
    endtask

    // called just after a rising edge; returns just after the edge that follows the handshake
    task automatic drive(input int port, input logic [2:0] op, input logic [TAG_W-1:0] tag,
                         input logic [31:0] a, input logic [31:0] b);
        logic ok;
        ok = 1'b0;
        if (port == 0) begin
            req0_op = op; req0_tag = tag; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_tag = tag; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL handshake_timeout: port %0d tag %0d not accepted, required acceptance", port, tag);
        end
        @(posedge clk); #1;
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: busy=%0d pending=%0d, required idle and drained", name, busy, sb_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_wb_valid", wb_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_in_en", mul_in_en, 0);
        check("reset_mul_a", mul_a, 0);
        check("reset_mul_b", mul_b, 0);
        check("reset_signs", {mul_a_signed, mul_b_signed}, 0);
        rst_n = 1'b1;
        wb_ready = 1'b1;
        @(posedge clk); #1;

        expect_wb(5'd3, 32'hFFFFFFEB);
        drive(0, 3'b000, 5'd3, 32'hFFFFFFFD, 32'd7);
        wait_idle("mul");
        check("mul_signs", {last_as, last_bs}, 2'b11);

        expect_wb(5'd5, 32'h40000000);
        drive(1, 3'b001, 5'd5, 32'h80000000, 32'h80000000);
        wait_idle("mulh");
        check("mulh_signs", {last_as, last_bs}, 2'b11);

        expect_wb(5'd6, 32'hFFFFFFFE);
        drive(0, 3'b011, 5'd6, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle("mulhu");
        check("mulhu_signs", {last_as, last_bs}, 2'b00);

        expect_wb(5'd7, 32'hFFFFFFFF);
        drive(1, 3'b010, 5'd7, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle("mulhsu");
        check("mulhsu_signs", {last_as, last_bs}, 2'b10);

        // round robin: expected order fixed up front, independent of grant timing
        grant_log.delete();
        for (int k = 0; k < 4; k++) begin
            expect_wb(TAG_W'(k), 32'(3 * (k + 1)));
            expect_wb(TAG_W'(8 + k), 32'(3 * (9 + k)));
        end
        fork
            begin
                for (int k = 0; k < 4; k++) drive(0, 3'b000, TAG_W'(k), 32'(k + 1), 32'd3);
            end
            begin
                for (int k = 0; k < 4; k++) drive(1, 3'b000, TAG_W'(8 + k), 32'(9 + k), 32'd3);
            end
        join
        wait_idle("rr");
        check("rr_grant_count", grant_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            logic [TAG_W-1:0] g;
            g = (i < grant_log.size()) ? grant_log[i] : '1;
            check($sformatf("rr_grant_%0d", i), g, (i % 2 == 0) ? (i / 2) : (8 + i / 2));
        end

        // backpressure with a two-entry buffer
        wb_ready = 1'b0;
        grant_log.delete();
        expect_wb(5'd20, 32'd1);
        expect_wb(5'd21, 32'd4);
        expect_wb(5'd22, 32'd9);
        drive(0, 3'b000, 5'd20, 32'd1, 32'd1);
        drive(1, 3'b000, 5'd21, 32'd2, 32'd2);
        fork
            begin
                drive(0, 3'b000, 5'd22, 32'd3, 32'd3);
                bp_done = 1'b1;
            end
        join_none
        repeat (20) @(negedge clk);
        check("bp_grants_blocked", grant_log.size(), 2);
        check("bp_req0_ready", req0_ready, 0);
        check("bp_busy", busy, 1);
        check("bp_wb_valid", wb_valid, 1);
        check("bp_head_tag", wb_vregid, 20);
        check("bp_head_val", wb_val, 1);
        @(posedge clk); #1;
        wb_ready = 1'b1;
        for (int i = 0; i < 300 && !bp_done; i++) @(posedge clk);
        #1;
        check("bp_third_issued", bp_done, 1);
        wait_idle("bp");
        check("bp_third_grant", (grant_log.size() == 3) ? grant_log[2] : 5'h1F, 22);

        // flush while the multiply is outstanding
        drive(0, 3'b000, 5'd7, 32'd9, 32'd9);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy_drain", busy, 1);
        wait_idle("flush_wait");
        check("flush_no_wb", wb_valid, 0);
        expect_wb(5'd9, 32'd30);
        drive(0, 3'b000, 5'd9, 32'd5, 32'd6);
        wait_idle("after_flush");

        // flush in IDLE empties the buffer
        wb_ready = 1'b0;
        drive(1, 3'b000, 5'd13, 32'd4, 32'd4);
        repeat (8) @(posedge clk);
        #1;
        check("idle_flush_pre_valid", wb_valid, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("idle_flush_valid", wb_valid, 0);
        check("idle_flush_busy", busy, 0);

        // asynchronous reset while a result is buffered and another is in flight
        drive(0, 3'b000, 5'd12, 32'd1, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        drive(1, 3'b000, 5'd14, 32'd2, 32'd2);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("areset_wb_valid", wb_valid, 0);
        check("areset_in_en", mul_in_en, 0);
        check("areset_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wb_ready = 1'b1;
        expect_wb(5'd1, 32'd6);
        drive(0, 3'b000, 5'd1, 32'd2, 32'd3);
        wait_idle("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
